// File: rtl/alu_instr_issue.sv
// Single-issue decode/operand front end for a combinational 32-bit ALU.
// Optional macro OVERFLOW_TRAP_EN: signed-overflow trap on ADD/SUB/ADDI.
module alu_instr_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_instr_valid,
  output logic            o_instr_ready,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_op,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_alu_zero,
  input  logic            i_alu_overflow,
  input  logic            i_alu_carry_out,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_addr,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_wb_zero,
  output logic            o_wb_carry,
  output logic            o_illegal,
  output logic            o_ovf_trap,
  input  logic [4:0]      i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data
);

`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  localparam logic [3:0] A_ADD = 4'd0;
  localparam logic [3:0] A_SUB = 4'd1;
  localparam logic [3:0] A_AND = 4'd2;
  localparam logic [3:0] A_OR  = 4'd3;
  localparam logic [3:0] A_XOR = 4'd4;
  localparam logic [3:0] A_NOR = 4'd5;
  localparam logic [3:0] A_SLT = 4'd6;
  localparam logic [3:0] A_SLL = 4'd7;
  localparam logic [3:0] A_SRL = 4'd8;
  localparam logic [3:0] A_SRA = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEC,
    S_EXE,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rf [NREGS];
  logic [4:0]      r_dest;
  logic            r_legal;
  logic            r_trapable;

  logic            w_accept;
  logic [5:0]      w_opc;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_sh;
  logic [5:0]      w_fn;
  logic [15:0]     w_imm;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic [XLEN-1:0] w_sext;
  logic [XLEN-1:0] w_zext;
  logic [XLEN-1:0] w_shamt;

  logic [3:0]      w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [4:0]      w_dest;
  logic            w_legal;
  logic            w_trapable;

  logic            w_trap;
  logic            w_wr_ok;
  logic            w_wr_en;

  assign w_accept = i_instr_valid & o_instr_ready;

  assign w_opc = r_instr[31:26];
  assign w_rs  = r_instr[25:21];
  assign w_rt  = r_instr[20:16];
  assign w_rd  = r_instr[15:11];
  assign w_sh  = r_instr[10:6];
  assign w_fn  = r_instr[5:0];
  assign w_imm = r_instr[15:0];

  assign w_rs_val = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
  assign w_sext   = {{(XLEN-16){w_imm[15]}}, w_imm};
  assign w_zext   = {{(XLEN-16){1'b0}}, w_imm};
  assign w_shamt  = {{(XLEN-5){1'b0}}, w_sh};

  assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_rf[i_dbg_addr];

  // Overflow only matters for the trapping adds, and only when enabled.
  assign w_trap  = TRAP_EN & r_legal & r_trapable & i_alu_overflow;
  assign w_wr_ok = r_legal & ~w_trap;
  assign w_wr_en = (r_state == S_EXE) & w_wr_ok & (r_dest != 5'd0);

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state: WB may chain straight into a new DEC
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_accept ? S_DEC : S_IDLE;
      S_DEC:  w_next = S_EXE;
      S_EXE:  w_next = S_WB;
      S_WB:   w_next = w_accept ? S_DEC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: accept words only in IDLE and WB
  always_comb begin
    o_instr_ready = 1'b0;
    case (r_state)
      S_IDLE:  o_instr_ready = 1'b1;
      S_WB:    o_instr_ready = 1'b1;
      default: o_instr_ready = 1'b0;
    endcase
  end

  // Decode the latched word into op, operands and destination
  always_comb begin
    w_op       = A_ADD;
    w_a        = w_rs_val;
    w_b        = w_rt_val;
    w_dest     = w_rd;
    w_legal    = 1'b1;
    w_trapable = 1'b0;
    case (w_opc)
      OP_R: begin
        case (w_fn)
          6'h20: begin
            w_op       = A_ADD;
            w_trapable = 1'b1;
          end
          6'h22: begin
            w_op       = A_SUB;
            w_trapable = 1'b1;
          end
          6'h24: w_op = A_AND;
          6'h25: w_op = A_OR;
          6'h26: w_op = A_XOR;
          6'h27: w_op = A_NOR;
          6'h2A: w_op = A_SLT;
          6'h00: begin
            w_op = A_SLL;
            w_a  = w_shamt;
          end
          6'h02: begin
            w_op = A_SRL;
            w_a  = w_shamt;
          end
          6'h03: begin
            w_op = A_SRA;
            w_a  = w_shamt;
          end
          6'h04: w_op = A_SLL;
          6'h06: w_op = A_SRL;
          6'h07: w_op = A_SRA;
          default: w_legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_op       = A_ADD;
        w_b        = w_sext;
        w_dest     = w_rt;
        w_trapable = 1'b1;
      end
      OP_SLTI: begin
        w_op   = A_SLT;
        w_b    = w_sext;
        w_dest = w_rt;
      end
      OP_ANDI: begin
        w_op   = A_AND;
        w_b    = w_zext;
        w_dest = w_rt;
      end
      OP_ORI: begin
        w_op   = A_OR;
        w_b    = w_zext;
        w_dest = w_rt;
      end
      OP_XORI: begin
        w_op   = A_XOR;
        w_b    = w_zext;
        w_dest = w_rt;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Latch the accepted word, then register ALU drive in DEC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr    <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      r_dest     <= '0;
      r_legal    <= 1'b0;
      r_trapable <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr <= i_instr;
      end
      if (r_state == S_DEC) begin
        o_alu_a    <= w_a;
        o_alu_b    <= w_b;
        o_alu_op   <= w_op;
        r_dest     <= w_dest;
        r_legal    <= w_legal;
        r_trapable <= w_trapable;
      end
    end
  end

  // Capture ALU result at end of EXE; pulses live for the WB cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_valid <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      o_wb_zero  <= 1'b0;
      o_wb_carry <= 1'b0;
      o_illegal  <= 1'b0;
      o_ovf_trap <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      o_illegal  <= 1'b0;
      o_ovf_trap <= 1'b0;
      if (r_state == S_EXE) begin
        o_wb_valid <= w_wr_ok;
        o_illegal  <= ~r_legal;
        o_ovf_trap <= w_trap;
        if (w_wr_ok) begin
          o_wb_addr  <= r_dest;
          o_wb_data  <= i_alu_result;
          o_wb_zero  <= i_alu_zero;
          o_wb_carry <= i_alu_carry_out;
        end
      end
    end
  end

  // Register file; entry 0 is never written
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_rf[r_dest] <= i_alu_result;
    end
  end

endmodule

// File: tb/tb_alu_instr_issue.sv
// Scoreboard bench for alu_instr_issue with a behavioural ALU.
// Define OVERFLOW_TRAP_EN here as well when building the trapping variant.
module tb_alu_instr_issue;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [31:0] i_instr;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [3:0]  o_alu_op;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_v;
  logic        alu_c;
  logic        o_wb_valid;
  logic [4:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic        o_wb_zero;
  logic        o_wb_carry;
  logic        o_illegal;
  logic        o_ovf_trap;
  logic [4:0]  i_dbg_addr;
  logic [31:0] o_dbg_data;

  always #5 clk = ~clk;

  alu_instr_issue dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_instr_valid  (i_instr_valid),
    .o_instr_ready  (o_instr_ready),
    .i_instr        (i_instr),
    .o_alu_a        (o_alu_a),
    .o_alu_b        (o_alu_b),
    .o_alu_op       (o_alu_op),
    .i_alu_result   (alu_res),
    .i_alu_zero     (alu_zero),
    .i_alu_overflow (alu_v),
    .i_alu_carry_out(alu_c),
    .o_wb_valid     (o_wb_valid),
    .o_wb_addr      (o_wb_addr),
    .o_wb_data      (o_wb_data),
    .o_wb_zero      (o_wb_zero),
    .o_wb_carry     (o_wb_carry),
    .o_illegal      (o_illegal),
    .o_ovf_trap     (o_ovf_trap),
    .i_dbg_addr     (i_dbg_addr),
    .o_dbg_data     (o_dbg_data)
  );

  // Behavioural alu_32bit
  logic [32:0] s;
  always_comb begin
    s       = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (o_alu_op)
      4'd0: begin
        s       = {1'b0, o_alu_a} + {1'b0, o_alu_b};
        alu_res = s[31:0];
        alu_c   = s[32];
        alu_v   = (o_alu_a[31] == o_alu_b[31]) &&
                  (alu_res[31] != o_alu_a[31]);
      end
      4'd1: begin
        s       = {1'b0, o_alu_a} + {1'b0, ~o_alu_b} + 33'd1;
        alu_res = s[31:0];
        alu_c   = s[32];
        alu_v   = (o_alu_a[31] != o_alu_b[31]) &&
                  (alu_res[31] != o_alu_a[31]);
      end
      4'd2: alu_res = o_alu_a & o_alu_b;
      4'd3: alu_res = o_alu_a | o_alu_b;
      4'd4: alu_res = o_alu_a ^ o_alu_b;
      4'd5: alu_res = ~(o_alu_a | o_alu_b);
      4'd6: alu_res = {31'b0, $signed(o_alu_a) < $signed(o_alu_b)};
      4'd7: alu_res = o_alu_b << o_alu_a[4:0];
      4'd8: alu_res = o_alu_b >> o_alu_a[4:0];
      4'd9: alu_res = $signed(o_alu_b) >>> o_alu_a[4:0];
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on every result pulse
  always @(negedge clk) begin
    exp_t e;
    int   k;
    int   n;
    if (o_wb_valid || o_illegal || o_ovf_trap) begin
      k = o_wb_valid ? 0 : (o_illegal ? 1 : 2);
      n = int'(o_wb_valid) + int'(o_illegal) + int'(o_ovf_trap);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got kind=%0d required none", k);
      end else begin
        e = q.pop_front();
        if (n != 1 || k != e.kind || cyc != e.cyc ||
            (k == 0 && (o_wb_addr != e.addr ||
                        o_wb_data != e.data ||
                        o_wb_zero != (e.data == 32'd0)))) begin
          errors++;
          $display("FAIL result got kind=%0d n=%0d addr=%0d data=%h z=%0b cyc=%0d required kind=%0d addr=%0d data=%h cyc=%0d",
                   k, n, o_wb_addr, o_wb_data, o_wb_zero, cyc,
                   e.kind, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] rtype(int rs, int rt, int rd,
                                        int sh, int fn);
    logic [4:0] a, b, c, d;
    logic [5:0] f;
    a = rs[4:0];
    b = rt[4:0];
    c = rd[4:0];
    d = sh[4:0];
    f = fn[5:0];
    return {6'h00, a, b, c, d, f};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    logic [5:0]  o;
    logic [4:0]  a, b;
    logic [15:0] m;
    o = op[5:0];
    a = rs[4:0];
    b = rt[4:0];
    m = imm[15:0];
    return {o, a, b, m};
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  task automatic chk_reg(input int a, input logic [31:0] exp);
    i_dbg_addr = a[4:0];
    #1;
    check($sformatf("dbg_r%0d", a), o_dbg_data, exp);
  endtask

  // Present a word; when accepted, queue its expected result
  task automatic issue(input logic [31:0] ins, input int kind,
                       input int addr, input logic [31:0] data,
                       input bit push);
    exp_t e;
    bit   done;
    @(negedge clk);
    i_instr       = ins;
    i_instr_valid = 1'b1;
    done          = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (o_instr_ready) begin
        if (push) begin
          e.kind = kind;
          e.addr = addr[4:0];
          e.data = data;
          e.cyc  = cyc + 3;
          q.push_back(e);
        end
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout got no accept required accept instr=%h",
               ins);
    end
  endtask

  task automatic drain();
    bit done;
    @(negedge clk);
    i_instr_valid = 1'b0;
    done          = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      if (q.size() == 0 && o_instr_ready) done = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d required 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] last;
    int          bad;
    i_rst         = 1'b1;
    i_instr_valid = 1'b0;
    i_instr       = '0;
    i_dbg_addr    = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    check("rst_ready", {31'b0, o_instr_ready}, 32'd1);
    check("rst_pulses", {29'b0, o_wb_valid, o_illegal, o_ovf_trap}, 32'd0);
    check("rst_alu_op", {28'b0, o_alu_op}, 32'd0);
    check("rst_wb_data", o_wb_data, 32'd0);
    chk_reg(1, 32'd0);

    // ADDI pair, then SUB chained back-to-back
    issue(itype('h08, 0, 1, 5), 0, 1, 32'd5, 1);
    issue(itype('h08, 0, 2, 'hFFFD), 0, 2, 32'hFFFFFFFD, 1);
    issue(rtype(1, 2, 3, 0, 'h22), 0, 3, 32'd8, 1);
    @(negedge clk);
    @(negedge clk);
    check("exe_sub_op", {28'b0, o_alu_op}, 32'd1);
    // SRA by shamt and SLT
    issue(rtype(0, 2, 4, 1, 'h03), 0, 4, 32'hFFFFFFFE, 1);
    @(negedge clk);
    @(negedge clk);
    check("exe_sra_a", o_alu_a, 32'd1);
    check("exe_sra_op", {28'b0, o_alu_op}, 32'd9);
    issue(rtype(2, 1, 5, 0, 'h2A), 0, 5, 32'd1, 1);
    drain();
    chk_reg(1, 32'd5);
    chk_reg(2, 32'hFFFFFFFD);
    chk_reg(3, 32'd8);
    chk_reg(4, 32'hFFFFFFFE);
    chk_reg(5, 32'd1);

    // ORI zero-extend, write to r0
    issue(itype('h0D, 0, 6, 'h8000), 0, 6, 32'h00008000, 1);
    issue(rtype(1, 1, 0, 0, 'h20), 0, 0, 32'd10, 1);
    drain();
    chk_reg(6, 32'h00008000);
    chk_reg(0, 32'd0);
    check("hold_wb_addr", {27'b0, o_wb_addr}, 32'd0);

    // Remaining encodings
    issue(itype('h0E, 2, 9, 'hFFFF), 0, 9, 32'hFFFF0002, 1);
    issue(itype('h0A, 2, 10, 'hFFFE), 0, 10, 32'd1, 1);
    issue(itype('h0C, 2, 11, 'h00F0), 0, 11, 32'h000000F0, 1);
    issue(rtype(1, 0, 12, 0, 'h27), 0, 12, 32'hFFFFFFFA, 1);
    issue(rtype(1, 2, 13, 0, 'h06), 0, 13, 32'h07FFFFFF, 1);
    issue(rtype(1, 2, 14, 0, 'h26), 0, 14, 32'hFFFFFFF8, 1);
    issue(rtype(1, 1, 15, 0, 'h22), 0, 15, 32'd0, 1);
    drain();
    chk_reg(13, 32'h07FFFFFF);
    chk_reg(15, 32'd0);

    // Build 0x7FFFFFFF then overflow it
    issue(itype('h0D, 0, 7, 'h7FFF), 0, 7, 32'h00007FFF, 1);
    issue(rtype(0, 7, 7, 16, 'h00), 0, 7, 32'h7FFF0000, 1);
    issue(itype('h0D, 7, 7, 'hFFFF), 0, 7, 32'h7FFFFFFF, 1);
`ifdef OVERFLOW_TRAP_EN
    issue(rtype(7, 1, 8, 0, 'h20), 2, 0, 32'd0, 1);
    last = 32'h7FFFFFFF;
    drain();
    chk_reg(8, 32'd0);
`else
    issue(rtype(7, 1, 8, 0, 'h20), 0, 8, 32'h80000004, 1);
    last = 32'h80000004;
    drain();
    chk_reg(8, 32'h80000004);
`endif

    // Illegal encodings: no write, outputs hold
    issue(32'hFC000000, 1, 0, 32'd0, 1);
    issue(rtype(1, 2, 20, 0, 'h3F), 1, 0, 32'd0, 1);
    drain();
    chk_reg(20, 32'd0);
    check("hold_wb_data", o_wb_data, last);

    // Reset during EXE discards the instruction
    issue(itype('h08, 0, 16, 7), 0, 0, 32'd0, 0);
    @(negedge clk);
    @(negedge clk);
    i_rst         = 1'b1;
    i_instr_valid = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    check("rst_exe_ready", {31'b0, o_instr_ready}, 32'd1);
    check("rst_exe_wb_data", o_wb_data, 32'd0);
    repeat (4) @(negedge clk);
    bad = 0;
    for (int r = 1; r < 32; r++) begin
      i_dbg_addr = r[4:0];
      #1;
      if (o_dbg_data != 32'd0) bad++;
    end
    check("rst_exe_regs_nonzero", bad, 32'd0);

    // Reset beats a same-cycle handshake
    @(negedge clk);
    i_instr       = itype('h08, 0, 17, 9);
    i_instr_valid = 1'b1;
    i_rst         = 1'b1;
    @(negedge clk);
    i_rst         = 1'b0;
    i_instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk_reg(17, 32'd0);

    check("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
